// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: serial A/B/op loader with strobe synchroniser, drives the tile ALU and registers its result.
// Rev 1.0
`default_nettype none

module alu_op_sequencer #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ALU_LAT     = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              load_stb_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [1:0]        alu_sel_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic [2:0]        state_dbg_o
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // fill_q marks which flops hold genuine post-reset samples, so a pin already
  // high at reset release is never mistaken for a rising edge.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   stb_p;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], load_stb_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign stb_p = sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES];

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              valid_q, valid_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      lat_q   <= lat_d;
    end
  end

  // Strobe pulses arriving while ena_i is low simply fall through unused.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    valid_d = valid_q;
    lat_d   = lat_q;
    if (ena_i) begin
      if (clr_i) begin
        state_d = S_IDLE;
        a_d     = '0;
        b_d     = '0;
        sel_d   = '0;
        res_d   = '0;
        valid_d = 1'b0;
        lat_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (stb_p) begin
              a_d     = data_in_i;
              valid_d = 1'b0;
              state_d = S_GET_B;
            end
          end
          S_GET_B: begin
            if (stb_p) begin
              b_d     = data_in_i;
              state_d = S_GET_OP;
            end
          end
          S_GET_OP: begin
            if (stb_p) begin
              sel_d   = data_in_i[1:0];
              lat_d   = LAT_LOAD;
              state_d = S_EXEC;
            end
          end
          S_EXEC: begin
            if (lat_q == '0) begin
              res_d   = alu_result_i;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              lat_d = lat_q - LAT_ONE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_sel_o      = sel_q;
  assign result_o       = res_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign state_dbg_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios plus random traffic against a cycle-level reference model.
`default_nettype none

module tb_alu_op_sequencer;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int AL = 4;

  logic          clk = 1'b0;
  logic          rst_n, ena, load_stb, clr;
  logic [DW-1:0] data_in, alu_a, alu_b, alu_result, result;
  logic [1:0]    alu_sel;
  logic          result_valid, busy;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DW), .SYNC_STAGES(SS), .ALU_LAT(AL)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ena_i          (ena),
    .data_in_i      (data_in),
    .load_stb_i     (load_stb),
    .clr_i          (clr),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_sel_o      (alu_sel),
    .alu_result_i   (alu_result),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy),
    .state_dbg_o    (state_dbg)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [1:0] s);
    logic [DW-1:0] r;
    case (s)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0..3 = idle, want B, want op, executing.
  int            m_phase, m_cnt;
  logic [DW-1:0] m_a, m_b, m_res;
  logic [1:0]    m_sel;
  logic          m_valid;
  bit            hist[$];

  task automatic model_reset();
    m_phase = 0; m_cnt = 0;
    m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_valid = 1'b0;
    hist.delete();
  endtask

  // A pin rise first sampled at edge n-SS is acted on at edge n; both samples
  // must have been taken after reset release.
  task automatic model_step();
    int n;
    bit pulse;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n = hist.size();
    pulse = (n >= SS + 1) && hist[n-SS] && !hist[n-SS-1];
    hist.push_back(load_stb);
    if (hist.size() > 16) void'(hist.pop_front());
    if (ena) begin
      if (clr) begin
        m_phase = 0; m_cnt = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_valid = 1'b0;
      end else begin
        case (m_phase)
          0: if (pulse) begin m_a = data_in; m_valid = 1'b0; m_phase = 1; end
          1: if (pulse) begin m_b = data_in; m_phase = 2; end
          2: if (pulse) begin m_sel = data_in[1:0]; m_cnt = AL; m_phase = 3; end
          default: begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_res = alu_f(m_a, m_b, m_sel);
              m_valid = 1'b1;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
    check_eq("alu_sel", alu_sel, m_sel);
    check_eq("result", result, m_res);
    check_eq("result_valid", result_valid, m_valid);
    check_eq("busy", busy, m_phase != 0);
    check_eq("state_dbg", state_dbg, m_phase);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pin_cycle(input logic [DW-1:0] d, input int hi, input int lo);
    data_in  = d;
    load_stb = 1'b1;
    repeat (hi) tick();
    load_stb = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic load(input logic [DW-1:0] d);
    pin_cycle(d, 3, 3);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; load_stb = 1'b0; clr = 1'b0; data_in = '0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_state", state_dbg, 3'd0);
    check_eq("rst_valid", result_valid, 1'b0);

    // 1: add
    load(8'h35); load(8'h0A); load(8'h00);
    repeat (AL) tick();
    check_eq("t1_a", alu_a, 8'h35);
    check_eq("t1_b", alu_b, 8'h0A);
    check_eq("t1_sel", alu_sel, 2'd0);
    check_eq("t1_res", result, 8'h3F);
    check_eq("t1_valid", result_valid, 1'b1);
    check_eq("t1_busy", busy, 1'b0);

    // 2: subtract with wrap, junk in upper op bits
    load(8'h05); load(8'h07); load(8'hFD);
    repeat (AL) tick();
    check_eq("t2_sel", alu_sel, 2'd1);
    check_eq("t2_res", result, 8'hFE);

    // 3: second strobe lands inside EXEC and must be dropped
    load(8'h11); load(8'h22);
    pin_cycle(8'h03, 3, 1);
    pin_cycle(8'h99, 3, 3);
    repeat (AL) tick();
    check_eq("t3_state", state_dbg, 3'd0);
    check_eq("t3_res", result, 8'h33);
    check_eq("t3_valid", result_valid, 1'b1);
    pin_cycle(8'h44, 3, 0);
    check_eq("t3_newa", alu_a, 8'h44);
    check_eq("t3_vclr", result_valid, 1'b0);
    repeat (3) tick();
    load(8'h10); load(8'h01);
    repeat (AL) tick();
    check_eq("t3_res2", result, 8'h34);

    // 4: clr coincident with the op strobe
    load(8'hAA); load(8'hBB);
    data_in = 8'h03; load_stb = 1'b1;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t4_state", state_dbg, 3'd0);
    check_eq("t4_a", alu_a, 8'h00);
    check_eq("t4_res", result, 8'h00);
    load_stb = 1'b0;
    repeat (3) tick();
    load(8'h01); load(8'h02); load(8'h00);
    repeat (AL) tick();
    check_eq("t4_res2", result, 8'h03);

    // 5: freeze spanning a strobe edge
    load(8'h09);
    ena = 1'b0;
    pin_cycle(8'h77, 3, 3);
    repeat (4) tick();
    ena = 1'b1;
    repeat (4) tick();
    check_eq("t5_state", state_dbg, 3'd1);
    check_eq("t5_b", alu_b, 8'h02);
    load(8'h08); load(8'h00);
    repeat (AL) tick();
    check_eq("t5_res", result, 8'h11);

    // 6: async reset during EXEC with the pin held high
    load(8'h50); load(8'h20);
    pin_cycle(8'h01, 3, 0);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("t6_state", state_dbg, 3'd0);
    check_eq("t6_res", result, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check_eq("t6_nospur", state_dbg, 3'd0);
    load_stb = 1'b0;
    repeat (2) tick();
    pin_cycle(8'h12, 3, 1);
    check_eq("t6_reload", alu_a, 8'h12);

    // Random traffic
    repeat (1500) begin
      if ($urandom_range(2) == 0) load_stb = ~load_stb;
      data_in = DW'($urandom);
      ena     = ($urandom_range(7) != 0);
      clr     = ($urandom_range(40) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
